// File: rtl/uart_pkg.sv
// Shared UART definitions: idle/empty read value and the receive-acknowledge
// FSM state encoding.
package uart_pkg;

  localparam logic [31:0] UartIdle = 32'hFFFF_FFFF;

  typedef enum logic {
    RECEIVE = 1'b0,
    ACK     = 1'b1
  } uart_ack_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Register-array synchronous FIFO with an explicit occupancy counter.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int Width         = 8,
  parameter int DepthBitWidth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic                     push_accept,
  output logic [Width-1:0]         head,
  output logic [DepthBitWidth:0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int Depth = 1 << DepthBitWidth;
  localparam logic [DepthBitWidth:0] Capacity = {1'b1, {DepthBitWidth{1'b0}}};

  logic [Width-1:0]         mem [Depth];
  logic [DepthBitWidth-1:0] wr_ptr;
  logic [DepthBitWidth-1:0] rd_ptr;
  logic                     pop_fire;

  assign empty       = (count == '0);
  assign full        = (count == Capacity);
  assign pop_fire    = pop & ~empty;
  assign push_accept = push & (~full | pop_fire);
  assign head        = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)    rd_ptr <= rd_ptr + 1'b1;
      case ({push_accept, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; occupancy tracking makes
  // stale contents unobservable and keeps the array as plain enabled flops.
  always_ff @(posedge clk) begin
    if (push_accept) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer between uartrx and the memory-mapped UART-in register:
// acknowledges each received byte, queues it, and counts bytes lost to overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DepthBitWidth        = 4,
  parameter int OverrunCountBitWidth = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_data_ready,
  output logic                            rx_go,
  input  logic                            read,
  output logic [31:0]                     data_out,
  output logic [DepthBitWidth:0]          count,
  output logic                            empty,
  output logic                            full,
  output logic                            overflow,
  output logic [OverrunCountBitWidth-1:0] overrun_count,
  input  logic                            clear_overflow
);

  uart_ack_state_e state_q, state_d;
  logic            taken_q;
  logic            push_req;
  logic            push_accept;
  logic            drop;
  logic [7:0]      head;

  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    rx_go    = 1'b1;
    push_req = 1'b0;
    case (state_q)
      RECEIVE: begin
        if (rx_data_ready && !taken_q) begin
          push_req = 1'b1;
          state_d  = ACK;
        end
      end
      ACK: begin
        rx_go   = 1'b0;
        state_d = RECEIVE;
      end
      default: state_d = RECEIVE;
    endcase
  end

  // taken_q stops a ready level held past the ACK cycle from being re-captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RECEIVE;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push_req)            taken_q <= 1'b1;
      else if (!rx_data_ready) taken_q <= 1'b0;
    end
  end

  sync_fifo #(
    .Width         (8),
    .DepthBitWidth (DepthBitWidth)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push_req),
    .push_data   (rx_data),
    .pop         (read),
    .push_accept (push_accept),
    .head        (head),
    .count       (count),
    .empty       (empty),
    .full        (full)
  );

  assign drop     = push_req & ~push_accept;
  assign data_out = empty ? UartIdle : {24'h0, head};

  // A drop in the same cycle as clear_overflow restarts the tally at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow      <= 1'b0;
      overrun_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow)      overrun_count <= OverrunCountBitWidth'(1);
      else if (!(&overrun_count)) overrun_count <= overrun_count + 1'b1;
    end else if (clear_overflow) begin
      overflow      <= 1'b0;
      overrun_count <= '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected read data,
// a negedge monitor checks data_out whenever read is asserted.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_data_ready;
  logic        rx_go;
  logic        read;
  logic [31:0] data_out;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic [7:0]  overrun_count;
  logic        clear_overflow;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  model[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DepthBitWidth        (4),
    .OverrunCountBitWidth (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_data_ready  (rx_data_ready),
    .rx_go          (rx_go),
    .read           (read),
    .data_out       (data_out),
    .count          (count),
    .empty          (empty),
    .full           (full),
    .overflow       (overflow),
    .overrun_count  (overrun_count),
    .clear_overflow (clear_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (read && !rst) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL read_unexpected: got %h expected no read", data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (data_out !== mon_exp) begin
          failures++;
          $display("FAIL read_data: got %h expected %h", data_out, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data       = b;
    rx_data_ready = 1'b1;
    tick();
    rx_data_ready = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [31:0] e);
    exp_q.push_back(e);
    read = 1'b1;
    tick();
    read = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    rx_data        = 8'h00;
    rx_data_ready  = 1'b0;
    read           = 1'b0;
    clear_overflow = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset state and read of an empty FIFO
    check("rst_rx_go", 32'(rx_go), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_overrun", 32'(overrun_count), 32'd0);
    check("rst_data_out", data_out, 32'hFFFF_FFFF);
    do_read(32'hFFFF_FFFF);
    check("empty_read_count", 32'(count), 32'd0);
    check("empty_read_rx_go", 32'(rx_go), 32'd1);

    // Three bytes in order, then -1
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h43);
    check("abc_count", 32'(count), 32'd3);
    do_read(32'h41);
    do_read(32'h42);
    do_read(32'h43);
    do_read(32'hFFFF_FFFF);
    check("abc_empty", 32'(empty), 32'd1);

    // Overfill: 17 bytes, then a second drop, then a drop coinciding with clear
    for (int i = 0; i <= 16; i++) send_byte(8'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_overflow", 32'(overflow), 32'd1);
    check("fill_overrun1", 32'(overrun_count), 32'd1);
    send_byte(8'h11);
    check("fill_overrun2", 32'(overrun_count), 32'd2);
    rx_data        = 8'h12;
    rx_data_ready  = 1'b1;
    clear_overflow = 1'b1;
    tick();
    rx_data_ready  = 1'b0;
    clear_overflow = 1'b0;
    tick();
    check("drop_vs_clear_overflow", 32'(overflow), 32'd1);
    check("drop_vs_clear_overrun", 32'(overrun_count), 32'd1);
    for (int i = 0; i < 16; i++) do_read(32'(i));
    do_read(32'hFFFF_FFFF);
    check("overflow_sticky", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("clear_overflow", 32'(overflow), 32'd0);
    check("clear_overrun", 32'(overrun_count), 32'd0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i));
    check("full2_full", 32'(full), 32'd1);
    exp_q.push_back(32'h80);
    rx_data       = 8'h55;
    rx_data_ready = 1'b1;
    read          = 1'b1;
    tick();
    rx_data_ready = 1'b0;
    read          = 1'b0;
    tick();
    check("pushpop_count", 32'(count), 32'd16);
    check("pushpop_overflow", 32'(overflow), 32'd0);
    for (int i = 1; i < 16; i++) do_read(32'h80 + 32'(i));
    do_read(32'h55);
    check("pushpop_empty", 32'(empty), 32'd1);

    // rx_data_ready held high for five cycles: one push, rx_go 1,0,1
    rx_data       = 8'h66;
    rx_data_ready = 1'b1;
    check("hold_go_a", 32'(rx_go), 32'd1);
    tick();
    check("hold_go_b", 32'(rx_go), 32'd0);
    tick();
    check("hold_go_c", 32'(rx_go), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_go_stay", 32'(rx_go), 32'd1);
    end
    rx_data_ready = 1'b0;
    tick();
    check("hold_count", 32'(count), 32'd1);
    do_read(32'h66);

    // 40 interleaved operations across the pointer wrap against a model queue
    for (int i = 0; i < 40; i++) begin
      int op;
      op = i % 4;
      if (op >= 2) begin
        if (model.size() == 0) exp_q.push_back(32'hFFFF_FFFF);
        else                   exp_q.push_back({24'h0, model.pop_front()});
        read = 1'b1;
      end
      if (op != 2) begin
        rx_data       = 8'hA0 + 8'(i);
        rx_data_ready = 1'b1;
        model.push_back(8'hA0 + 8'(i));
      end
      tick();
      read          = 1'b0;
      rx_data_ready = 1'b0;
      tick();
    end
    check("wrap_count", 32'(count), 32'(model.size()));
    while (model.size() != 0) do_read({24'h0, model.pop_front()});
    do_read(32'hFFFF_FFFF);
    check("wrap_empty", 32'(empty), 32'd1);

    // Reset during ACK with five bytes stored
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
    rx_data       = 8'hC4;
    rx_data_ready = 1'b1;
    tick();
    check("pre_rst_rx_go", 32'(rx_go), 32'd0);
    check("pre_rst_count", 32'(count), 32'd5);
    rst           = 1'b1;
    rx_data_ready = 1'b0;
    tick();
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_rx_go", 32'(rx_go), 32'd1);
    check("mid_rst_data_out", data_out, 32'hFFFF_FFFF);
    rst = 1'b0;
    tick();
    check("post_rst_empty", 32'(empty), 32'd1);

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
